uart_tx_arbiter: RTL and testbench

- Shares a single uart_transmitter between NUM_REQ byte-stream requesters (e.g. FIFO echo path, status/message generator, debug dump).
- Round-robin arbitration with packet locking: a granted requester keeps the transmitter until it flags its last byte or hits the MAX_PKT byte cap.
- Sits between the requesters and the transmitter's data/valid/ready port, in the CLKIN domain.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle for uart_tx_arbiter.
// slave = arbiter view, master = requesters/transmitter (testbench) view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant, busy
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to add the stall timeout and its timeout_evt output.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int MAX_PKT = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic CLKIN,
  input  logic RESET,
`ifdef UART_ARB_TIMEOUT_EN
  output logic timeout_evt,
`endif
  uart_tx_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         count_q, count_d;

  logic [7:0]         req_byte [NUM_REQ];
  logic [PTR_W:0]     cand;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_found;
  logic               locked;
  logic               owner_valid;
  logic               owner_last;
  logic               xfer;
  logic               release_pkt;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
    assign req_byte[gi] = bus.req_data[8*gi +: 8];
  end

  assign locked      = (state_q == LOCKED);
  assign owner_valid = bus.req_valid[owner_q];
  assign owner_last  = bus.req_last[owner_q];
  assign xfer        = locked && owner_valid && bus.tx_ready;

  // The datapath is a pure mux driven by the registered grant.
  assign bus.tx_valid  = locked && owner_valid;
  assign bus.tx_data   = locked ? req_byte[owner_q] : 8'h00;
  assign bus.req_ready = (locked && bus.tx_ready) ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.busy      = locked;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;

  assign timeout_evt = locked && !owner_valid && (stall_q == STALL_W'(TIMEOUT - 1));
`endif

  // First requester with valid set, scanning upward from ptr with wrap-around.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!pick_found && bus.req_valid[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    release_pkt = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    stall_d     = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCKED;
          grant_d = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          count_d = '0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          count_d     = count_q + 8'd1;
          release_pkt = owner_last || (count_q == 8'(MAX_PKT - 1));
        end
`ifdef UART_ARB_TIMEOUT_EN
        if (!owner_valid) begin
          if (timeout_evt) begin
            release_pkt = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
        if (release_pkt) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (owner / pointer / byte-count bookkeeping).
module tb_uart_tx_arbiter;
  localparam int NR = 3;
  localparam int MP = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
`ifdef UART_ARB_TIMEOUT_EN
  logic timeout_evt;
`endif

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_PKT(MP), .TIMEOUT(TO)) dut (
    .CLKIN(clk),
    .RESET(rst),
`ifdef UART_ARB_TIMEOUT_EN
    .timeout_evt(timeout_evt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // requester byte sources: {last, byte}
  logic [8:0] src_mem [NR][256];
  int         src_head [NR];
  int         src_tail [NR];
  logic [7:0] recv_mem [NR][256];
  int         recv_cnt [NR];
  bit [NR-1:0] en;

  // reference model state
  int m_owner, m_ptr, m_cnt, m_stall;

  // observed logs (from the DUT) and expected logs (from the test step)
  int grant_log[$];
  int xfer_log[$];
  int exp_g[$];
  int exp_x[$];
  logic [NR-1:0] prev_grant;
  int tevt_cnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push(int r, logic [7:0] b, bit last);
    if (src_tail[r] < 256) begin
      src_mem[r][src_tail[r]] = {last, b};
      src_tail[r]++;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (src_head[i] < src_tail[i] && en[i]) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
        bus.req_last[i]        = src_mem[i][src_head[i]][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'($urandom);
        bus.req_last[i]        = 1'($urandom);
      end
    end
  endtask

  // One clock: drive, check at negedge against the model, advance the model at posedge.
  task automatic cycle();
    int g, j, n_owner, n_ptr, n_cnt, n_stall, oi;
    logic [NR-1:0] eg, er;
    logic ev, et, rel;
    logic [7:0] ed;
    bit mx;
    drive_inputs();
    @(negedge clk);
    g  = m_owner;
    eg = '0; ev = 1'b0; ed = 8'h00; er = '0; et = 1'b0; mx = 1'b0;
    if (g >= 0) begin
      eg = NR'(1) << g;
      ev = bus.req_valid[g];
      ed = bus.req_data[8*g +: 8];
      er = bus.tx_ready ? eg : '0;
      mx = ev && bus.tx_ready;
      et = !ev && (m_stall == TO - 1);
    end
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("busy", 32'(bus.busy), 32'(g >= 0));
    chk("tx_valid", 32'(bus.tx_valid), 32'(ev));
    chk("tx_data", 32'(bus.tx_data), 32'(ed));
    chk("req_ready", 32'(bus.req_ready), 32'(er));
`ifdef UART_ARB_TIMEOUT_EN
    chk("timeout_evt", 32'(timeout_evt), 32'(et));
    if (timeout_evt === 1'b1) tevt_cnt++;
`endif
    if (prev_grant == '0 && bus.grant != '0) grant_log.push_back(oh_idx(bus.grant));
    prev_grant = bus.grant;
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      oi = oh_idx(bus.grant);
      xfer_log.push_back((oi << 8) | int'(bus.tx_data));
      if (oi >= 0 && recv_cnt[oi] < 256) begin
        recv_mem[oi][recv_cnt[oi]] = bus.tx_data;
        recv_cnt[oi]++;
      end
    end
    n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt; n_stall = 0; rel = 1'b0;
    if (rst) begin
      n_owner = -1; n_ptr = 0; n_cnt = 0;
    end else if (g < 0) begin
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (n_owner < 0 && bus.req_valid[j]) begin
          n_owner = j;
          n_cnt   = 0;
        end
      end
    end else begin
      if (mx) begin
        n_cnt = m_cnt + 1;
        if (bus.req_last[g] || m_cnt == MP - 1) rel = 1'b1;
      end
`ifdef UART_ARB_TIMEOUT_EN
      if (!ev) begin
        if (m_stall == TO - 1) rel = 1'b1;
        else n_stall = m_stall + 1;
      end
`endif
      if (rel) begin
        n_owner = -1;
        n_ptr   = (g + 1) % NR;
      end
    end
    @(posedge clk);
    m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt; m_stall = n_stall;
    if (mx) src_head[g]++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete(); xfer_log.delete(); exp_g.delete(); exp_x.delete();
  endtask

  task automatic drain(string tag, int budget);
    int left, n;
    en = '1;
    n = 0;
    left = 1;
    while (left != 0 && n < budget) begin
      cycle();
      n++;
      left = (m_owner >= 0) ? 1 : 0;
      for (int i = 0; i < NR; i++) left += src_tail[i] - src_head[i];
    end
    chk({tag, "_drained"}, 32'(left), 32'd0);
    cycle();
  endtask

  task automatic check_logs(string tag);
    chk({tag, "_ngrants"}, 32'(grant_log.size()), 32'(exp_g.size()));
    for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
      chk($sformatf("%s_grant%0d", tag, i), 32'(grant_log[i]), 32'(exp_g[i]));
    chk({tag, "_nxfers"}, 32'(xfer_log.size()), 32'(exp_x.size()));
    for (int i = 0; i < exp_x.size() && i < xfer_log.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), 32'(xfer_log[i]), 32'(exp_x[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, bad;
    for (int i = 0; i < NR; i++) begin
      src_head[i] = 0; src_tail[i] = 0; recv_cnt[i] = 0;
    end
    en = '1;
    tevt_cnt = 0;
    prev_grant = '0;
    bus.tx_ready = 1'b0;
    rst = 1'b1;
    drive_inputs();
    @(posedge clk);
    #1;
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0;

    // reset state
    do_reset();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // T1: requester 1, 2-byte packet; grant one cycle after request
    clear_logs();
    bus.tx_ready = 1'b1;
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b1);
    cycle();
    chk("t1_grant_latency", 32'(bus.grant), 32'h2);
    drain("t1", 20);
    exp_g = '{1};
    exp_x = '{(1 << 8) | 'h41, (1 << 8) | 'h42};
    check_logs("t1");

    // T1b: pointer now at 2, so requester 2 beats requester 0
    clear_logs();
    push(0, 8'h50, 1'b1); push(2, 8'h52, 1'b1);
    drain("t1b", 20);
    exp_g = '{2, 0};
    exp_x = '{(2 << 8) | 'h52, 'h50};
    check_logs("t1b");

    // T2: all three with 1-byte packets from ptr=0
    do_reset();
    clear_logs();
    push(0, 8'hA0, 1'b1); push(0, 8'hA3, 1'b1);
    push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1);
    drain("t2", 30);
    exp_g = '{0, 1, 2, 0};
    exp_x = '{'hA0, (1 << 8) | 'hA1, (2 << 8) | 'hA2, 'hA3};
    check_logs("t2");

    // T3: byte cap of 4 forces release mid-packet
    do_reset();
    clear_logs();
    for (int b = 0; b < 6; b++) push(0, 8'(8'h10 + b), b == 5);
    push(1, 8'h20, 1'b1);
    drain("t3", 40);
    exp_g = '{0, 1, 0};
    exp_x = '{'h10, 'h11, 'h12, 'h13, (1 << 8) | 'h20, 'h14, 'h15};
    check_logs("t3");

    // T4: tx_ready toggling holds the byte stable
    do_reset();
    clear_logs();
    push(0, 8'h55, 1'b0); push(0, 8'hAA, 1'b1);
    for (int c = 0; c < 6; c++) begin
      bus.tx_ready = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      cycle();
    end
    bus.tx_ready = 1'b1;
    drain("t4", 20);
    exp_g = '{0};
    exp_x = '{'h55, 'hAA};
    check_logs("t4");

    // T5: reset after byte 2 of a 5-byte packet
    do_reset();
    clear_logs();
    for (int b = 0; b < 5; b++) push(0, 8'(8'h60 + b), b == 4);
    n = 0;
    while (xfer_log.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("t5_two_bytes", 32'(xfer_log.size()), 32'd2);
    bus.tx_ready = 1'b0;
    do_reset();
    bus.tx_ready = 1'b1;
    chk("t5_grant_after_rst", 32'(bus.grant), 32'd0);
    chk("t5_txvalid_after_rst", 32'(bus.tx_valid), 32'd0);
    drain("t5", 30);
    exp_g = '{0, 0};
    exp_x = '{'h60, 'h61, 'h62, 'h63, 'h64};
    check_logs("t5");

`ifdef UART_ARB_TIMEOUT_EN
    // T6: owner stalls mid-packet, timeout hands the grant to requester 1
    do_reset();
    clear_logs();
    push(0, 8'h70, 1'b0); push(0, 8'h71, 1'b1); push(1, 8'h80, 1'b1);
    cycle();
    cycle();
    en[0] = 1'b0;
    for (int c = 0; c < 14; c++) cycle();
    drain("t6", 30);
    exp_g = '{0, 1, 0};
    exp_x = '{'h70, (1 << 8) | 'h80, 'h71};
    check_logs("t6");
    chk("t6_timeout_pulses", 32'(tevt_cnt), 32'd1);
`endif

    // T7: randomized traffic, random stalls and backpressure
    do_reset();
    for (int r = 0; r < NR; r++) begin
      for (int p = 0; p < 15; p++) begin
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++)
          push(r, 8'($urandom), (b == len - 1) && (p == 14 || $urandom_range(0, 4) != 0));
      end
    end
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++) en[r] = ($urandom_range(0, 9) < 8);
      bus.tx_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    bus.tx_ready = 1'b1;
    drain("t7", 2000);

    // every accepted byte arrived exactly once, in order, per requester
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("stream_len_r%0d", r), 32'(recv_cnt[r]), 32'(src_head[r]));
      bad = 0;
      for (int k = 0; k < recv_cnt[r] && k < src_head[r]; k++)
        if (recv_mem[r][k] !== src_mem[r][k][7:0]) bad++;
      chk($sformatf("stream_data_r%0d", r), 32'(bad), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
